// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: stepped f_sel sweep sequencer for the DDS tone generator.
// Optional ping-pong sweep enabled by defining DDS_SWEEP_PINGPONG_EN.
module dds_sweep_ctrl #(
    parameter int DWELL_W    = 16,
    parameter int GAP_CYCLES = 4,
    parameter int LOOP_W     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
`ifdef DDS_SWEEP_PINGPONG_EN
    input  logic               pingpong,
`endif
    input  logic [2:0]         f_lo,
    input  logic [2:0]         f_hi,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [LOOP_W-1:0]  loops,
    output logic [2:0]         f_sel,
    output logic               en,
    output logic               busy,
    output logic               step_stb,
    output logic               done
);
    typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;
    localparam int GAP_LOAD = GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0;
    state_t state;
    logic go;
    logic [2:0] f_lo_lat, f_hi_lat, nxt;
    logic [DWELL_W-1:0] dwell_lat, dcnt;
    logic [LOOP_W-1:0] loops_lat, loop_cnt, cnt_n;
    logic [15:0] gcnt;
    logic dir, dir_n, pp_lat, pp_mode, going_down, wrap, last;
`ifdef DDS_SWEEP_PINGPONG_EN
    // ping-pong mode flag captured together with the rest of the sweep setup
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) pp_lat <= 1'b0;
        else if (state == IDLE && start && !stop && !go) pp_lat <= pingpong;
`else
    assign pp_lat = 1'b0;
`endif
    // next step, loop wrap and completion decision taken at the end of each dwell
    always_comb begin
        pp_mode    = pp_lat && (f_hi_lat != f_lo_lat);
        going_down = pp_mode && (dir || f_sel == f_hi_lat);
        nxt        = going_down ? f_sel - 3'd1 : (f_sel == f_hi_lat ? f_lo_lat : f_sel + 3'd1);
        wrap       = pp_mode ? (going_down && nxt == f_lo_lat) : (f_sel == f_hi_lat);
        cnt_n      = loop_cnt + LOOP_W'(wrap);
        last       = (loops_lat != '0) && (pp_mode ? (!going_down && f_sel == f_lo_lat && loop_cnt == loops_lat)
                                                   : (wrap && cnt_n == loops_lat));
        dir_n      = going_down && (nxt != f_lo_lat);
    end
    // sweep FSM with registered DDS-facing outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            go        <= 1'b0;
            f_sel     <= '0;
            en        <= 1'b0;
            busy      <= 1'b0;
            step_stb  <= 1'b0;
            done      <= 1'b0;
            f_lo_lat  <= '0;
            f_hi_lat  <= '0;
            dwell_lat <= '0;
            loops_lat <= '0;
            loop_cnt  <= '0;
            dcnt      <= '0;
            gcnt      <= '0;
            dir       <= 1'b0;
        end else begin
            step_stb <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (stop) begin
                        go <= 1'b0;
                    end else if (go) begin
                        go       <= 1'b0;
                        state    <= RUN;
                        f_sel    <= f_lo_lat;
                        en       <= 1'b1;
                        step_stb <= 1'b1;
                        busy     <= 1'b1;
                        dcnt     <= dwell_lat - 1'b1;
                        loop_cnt <= '0;
                        dir      <= 1'b0;
                    end else if (start) begin
                        go        <= 1'b1;
                        f_lo_lat  <= f_lo;
                        f_hi_lat  <= (f_hi < f_lo) ? f_lo : f_hi;
                        dwell_lat <= (dwell == '0) ? DWELL_W'(1) : dwell;
                        loops_lat <= loops;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                        en    <= 1'b0;
                        busy  <= 1'b0;
                    end else if (dcnt != '0) begin
                        dcnt <= dcnt - 1'b1;
                    end else begin
                        loop_cnt <= cnt_n;
                        dir      <= dir_n;
                        if (last) begin
                            state <= DONE;
                            en    <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            f_sel <= nxt;
                            dcnt  <= dwell_lat - 1'b1;
                            if (GAP_CYCLES == 0) begin
                                step_stb <= 1'b1;
                            end else begin
                                state <= GAP;
                                en    <= 1'b0;
                                gcnt  <= 16'(GAP_LOAD);
                            end
                        end
                    end
                end
                GAP: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (gcnt != '0) begin
                        gcnt <= gcnt - 1'b1;
                    end else begin
                        state    <= RUN;
                        en       <= 1'b1;
                        step_stb <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: table-driven sweep checks plus directed stop/reset/start corner cases.
module tb_dds_sweep_ctrl;
    logic clk = 0, rst_n = 0, start = 0, stop = 0;
    logic [2:0] f_lo = 0, f_hi = 0, f_sel;
    logic [15:0] dwell = 0;
    logic [7:0] loops = 0;
    logic en, busy, step_stb, done;
`ifdef DDS_SWEEP_PINGPONG_EN
    logic pingpong = 0;
`endif
    int vec = 0, err = 0;

    dds_sweep_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
`ifdef DDS_SWEEP_PINGPONG_EN
        .pingpong(pingpong),
`endif
        .f_lo(f_lo), .f_hi(f_hi), .dwell(dwell), .loops(loops),
        .f_sel(f_sel), .en(en), .busy(busy), .step_stb(step_stb), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] lo, hi;
        logic [15:0] dw;
        logic [7:0] lp;
        logic pp;
        int steps;
        int done_cyc;
        logic [0:8][2:0] seq;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        vec++;
        if (act != exp) begin
            err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [2:0] lo, input logic [2:0] hi, input logic [15:0] dw, input logic [7:0] lp, input logic pp);
        @(negedge clk);
        f_lo = lo; f_hi = hi; dwell = dw; loops = lp; start = 1;
`ifdef DDS_SWEEP_PINGPONG_EN
        pingpong = pp;
`else
        if (pp) $display("note: ping-pong vector run without the feature");
`endif
        tick();
        start = 0;
        f_lo = 3'($urandom); f_hi = 3'($urandom); dwell = 16'($urandom_range(0, 9)); loops = 8'($urandom);
`ifdef DDS_SWEEP_PINGPONG_EN
        pingpong = ~pp;
`endif
    endtask

    vec_t tbl [7];
    int n;

    initial begin
        int ns, en_c, gap_c, dc, dwe, cnt, bad;
        logic [2:0] got [9];
        tbl[0] = '{3'd1, 3'd3, 16'd4, 8'd2, 1'b0, 6, 45, {3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0, 3'd0}};
        tbl[1] = '{3'd5, 3'd2, 16'd0, 8'd3, 1'b0, 3, 12, {3'd5, 3'd5, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}};
        tbl[2] = '{3'd0, 3'd0, 16'd2, 8'd1, 1'b0, 1, 3,  {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}};
        tbl[3] = '{3'd6, 3'd7, 16'd1, 8'd2, 1'b0, 4, 17, {3'd6, 3'd7, 3'd6, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}};
        tbl[4] = '{3'd7, 3'd7, 16'd3, 8'd2, 1'b0, 2, 11, {3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}};
        tbl[5] = '{3'd2, 3'd4, 16'd3, 8'd2, 1'b1, 9, 60, {3'd2, 3'd3, 3'd4, 3'd3, 3'd2, 3'd3, 3'd4, 3'd3, 3'd2}};
        tbl[6] = '{3'd1, 3'd3, 16'd4, 8'd2, 1'b1, 6, 45, {3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0, 3'd0}};
`ifdef DDS_SWEEP_PINGPONG_EN
        tbl[6].pp = 1'b0;
        n = 7;
`else
        n = 5;
`endif
        repeat (2) tick();
        chk("rst_f_sel", f_sel, 0);
        chk("rst_en", en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stb", step_stb, 0);
        chk("rst_done", done, 0);
        @(negedge clk) rst_n = 1;

        for (int v = 0; v < n; v++) begin
            dwe = tbl[v].dw == 0 ? 1 : int'(tbl[v].dw);
            go(tbl[v].lo, tbl[v].hi, tbl[v].dw, tbl[v].lp, tbl[v].pp);
            ns = 0; en_c = 0; gap_c = 0; dc = -1;
            for (int k = 1; k <= 400; k++) begin
                tick();
                if (dc >= 0) begin
                    chk("post_done_busy", busy, 0);
                    chk("post_done_en", en, 0);
                    break;
                end
                if (step_stb) begin
                    if (ns < 9) got[ns] = f_sel;
                    ns++;
                end
                if (en) en_c++;
                else if (busy && !done) gap_c++;
                if (done) begin
                    dc = k;
                    chk("done_busy", busy, 1);
                    chk("done_en", en, 0);
                end
            end
            chk($sformatf("v%0d_steps", v), ns, tbl[v].steps);
            chk($sformatf("v%0d_done_cycle", v), dc, tbl[v].done_cyc);
            chk($sformatf("v%0d_en_cycles", v), en_c, tbl[v].steps * dwe);
            chk($sformatf("v%0d_gap_cycles", v), gap_c, (tbl[v].steps - 1) * 4);
            for (int i = 0; i < tbl[v].steps && i < 9; i++)
                chk($sformatf("v%0d_f_sel[%0d]", v, i), (i < ns) ? int'(got[i]) : -1, int'(tbl[v].seq[i]));
        end

        go(3'd1, 3'd3, 16'd4, 8'd2, 1'b0);
        repeat (6) tick();
        chk("stop_pre_busy", busy, 1);
        chk("stop_pre_en", en, 0);
        stop = 1;
        tick();
        stop = 0;
        chk("stop_en", en, 0);
        chk("stop_busy", busy, 0);
        cnt = 0;
        repeat (60) begin
            tick();
            cnt += int'(done) + int'(busy);
        end
        chk("stop_no_done_busy", cnt, 0);
        go(3'd1, 3'd3, 16'd4, 8'd2, 1'b0);
        tick();
        chk("restart_stb", step_stb, 1);
        chk("restart_f_sel", f_sel, 1);
        @(negedge clk) stop = 1;
        tick();
        stop = 0;
        chk("restart_stop_busy", busy, 0);

        go(3'd0, 3'd1, 16'd2, 8'd0, 1'b0);
        ns = 0; bad = 0; cnt = 0;
        repeat (300) begin
            tick();
            if (step_stb) begin
                if (f_sel != 3'(ns % 2)) bad++;
                ns++;
            end
            cnt += int'(done);
        end
        chk("inf_busy", busy, 1);
        chk("inf_alt_bad", bad, 0);
        chk("inf_steps", ns, 50);
        chk("inf_no_done", cnt, 0);
        @(negedge clk) stop = 1;
        tick();
        stop = 0;
        chk("inf_stop_busy", busy, 0);
        chk("inf_stop_done", done, 0);

        go(3'd3, 3'd5, 16'd10, 8'd1, 1'b0);
        repeat (3) tick();
        chk("pre_rst_en", en, 1);
        #2 rst_n = 0;
        #1;
        chk("arst_en", en, 0);
        chk("arst_busy", busy, 0);
        chk("arst_f_sel", f_sel, 0);
        chk("arst_stb", step_stb, 0);
        chk("arst_done", done, 0);
        @(negedge clk) rst_n = 1;

        go(3'd1, 3'd1, 16'd4, 8'd1, 1'b0);
        ns = 0; dc = -1;
        for (int k = 1; k <= 20; k++) begin
            if (k == 3) begin
                @(negedge clk);
                f_lo = 3'd6; f_hi = 3'd6; dwell = 16'd1; loops = 8'd5; start = 1;
            end
            tick();
            start = 0;
            if (step_stb) ns++;
            if (done && dc < 0) begin
                dc = k;
                chk("busy_start_f_sel", f_sel, 1);
            end
        end
        chk("busy_start_steps", ns, 1);
        chk("busy_start_done", dc, 5);

        @(negedge clk);
        f_lo = 3'd2; f_hi = 3'd4; dwell = 16'd1; loops = 8'd1; start = 1; stop = 1;
        tick();
        start = 0; stop = 0;
        cnt = 0;
        repeat (5) begin
            tick();
            cnt += int'(busy) + int'(step_stb) + int'(en);
        end
        chk("start_stop_idle", cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Sequencer that drives the f_sel and en inputs of the DDS tone generator. It performs a stepped frequency sweep from f_lo to f_hi. Each step holds en high for a programmable dwell. Between steps, en drops for GAP_CYCLES so the DDS phase accumulator restarts at zero on each new tone. The sweep repeats for a programmed loop count or runs until stopped. The block sits between the control/key logic and the DDS instance.

Parameters:
DWELL_W, 16, width of dwell counter and dwell input
GAP_CYCLES, 4, en-low cycles between consecutive steps (0 = no gap, en stays high across step change)
LOOP_W, 8, width of loops input and loop counter

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle start request, honoured only in IDLE
stop  input  1  single-cycle abort request
f_lo  input  3  first f_sel of sweep
f_hi  input  3  last f_sel of sweep
dwell  input  DWELL_W  en-high cycles per step (0 treated as 1)
loops  input  LOOP_W  sweeps to run (0 = infinite)
f_sel  output  3  registered, to DDS f_sel
en  output  1  registered, to DDS en
busy  output  1  high in any state except IDLE
step_stb  output  1  1-cycle pulse in the first en-high cycle of every step
done  output  1  1-cycle pulse on normal completion

Behaviour:
- Reset (async, rst_n=0): state=IDLE; f_sel=0, en=0, busy=0, step_stb=0, done=0; all counters cleared. Outputs go low immediately, including mid-sweep.
- Clock, reset and the DDS share one clock domain. All outputs are registered.
- States: IDLE, RUN, GAP, DONE.
- IDLE:
  - en=0.
  - start=1 at edge N: latch f_lo, f_hi, dwell, loops. If f_hi<f_lo, use f_hi_lat=f_lo (single-tone sweep). If dwell=0, use dwell_lat=1.
  - At edge N+1: state=RUN, f_sel=f_lo, en=1, step_stb=1, busy=1.
- RUN:
  - en=1 for exactly dwell_lat cycles.
  - At the end of dwell, if f_sel<f_hi_lat: next step is f_sel+1.
  - At the end of dwell, if f_sel==f_hi_lat: loop_cnt+1. If loops≠0 and loop_cnt reaches loops, go to DONE. Otherwise the next step is f_lo_lat.
  - If the sweep continues and GAP_CYCLES>0: go to GAP with en=0, and f_sel updates to the next step on GAP entry.
  - If GAP_CYCLES=0: stay in RUN, update f_sel, keep en=1, pulse step_stb.
- GAP:
  - en=0 for exactly GAP_CYCLES cycles.
  - Then go to RUN with en=1 and step_stb=1.
  - f_sel changes only at GAP entry.
- DONE:
  - Lasts one cycle: en=0, done=1, busy=1.
  - Then IDLE with busy=0. f_sel holds its last value.
- Loop counter: LOOP_W bits. In infinite mode (loops=0) it wraps silently and never terminates.
- stop=1 in RUN, GAP or DONE: next cycle is IDLE with en=0 and busy=0. No done pulse; a pending done is suppressed.
- start while busy is ignored. Latched configuration does not change mid-sweep.
- start and stop asserted together in IDLE: stop wins and the block stays IDLE.
- Input changes to f_lo/f_hi/dwell/loops while busy have no effect.

Optional Feature:
Macro DDS_SWEEP_PINGPONG_EN.
- Defined: adds input port pingpong (1 bit, latched at start). When pingpong=1:
  - One loop runs f_lo..f_hi then f_hi-1 down to f_lo+1; endpoints are not repeated at turnarounds.
  - The final loop ends with a downward step to f_lo_lat before DONE.
  - When f_hi_lat==f_lo_lat, behaves as single tone.
  - When pingpong=0, behaviour is identical to sawtooth.
- Undefined: port absent; sawtooth sweep only.

Test Plan:
1. GAP_CYCLES=4, f_lo=1, f_hi=3, dwell=4, loops=2, start at cycle 0 -> f_sel sequence 1,2,3,1,2,3; en high 4 cycles per step; en low 4 cycles between steps; step_stb pulses 6 times; done=1 at cycle 45; busy=0 at cycle 46.
2. Same setup, stop at cycle 6 -> en=0 and busy=0 from cycle 7; done never asserts; a subsequent start is accepted at once.
3. f_lo=5, f_hi=2, dwell=0, loops=3 -> f_sel stays 5; three 1-cycle en pulses separated by 4-cycle gaps; done after the third pulse.
4. loops=0, f_lo=0, f_hi=1, dwell=2 -> sweep still running after 300 cycles with f_sel alternating 0,1; stop ends it with no done.
5. Drive rst_n low mid-RUN -> en, busy, f_sel, step_stb and done read 0 immediately, before the next clk edge. start while busy and start+stop in IDLE are both ignored.
6. With DDS_SWEEP_PINGPONG_EN, pingpong=1, f_lo=2, f_hi=4, loops=2, dwell=3 -> f_sel sequence 2,3,4,3,2,3,4,3,2; then done.
